// File: rtl/three_bit_serial_subtractor_if.sv
// ============================================================================
// Module   : three_bit_serial_subtractor_if
// Brief    : Operand/result bundle for the bit-serial subtractor.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface three_bit_serial_subtractor_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               in_start;
    logic [2*WIDTH-1:0] d_out;
    logic               b_out;
    logic               busy;
    logic               done;

    modport master (
        output in_a, in_b, in_start,
        input  d_out, b_out, busy, done
    );

    modport slave (
        input  in_a, in_b, in_start,
        output d_out, b_out, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/three_bit_serial_subtractor.sv
// ============================================================================
// Module   : three_bit_serial_subtractor
// Brief    : LSB-first bit-serial a - b with start/busy/done handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module three_bit_serial_subtractor #(
    parameter int WIDTH = 3
) (
    input  wire                                  clk,
    input  wire                                  rst,
    three_bit_serial_subtractor_if.slave         bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_br;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_d_out;
    logic               r_b_out;
    logic               w_busy;
    logic               w_done;
    logic               w_diff;
    logic               w_br_next;
    logic               w_last;
    logic               w_accept;

    // Full-subtractor cell on the current LSBs and the stored borrow
    assign w_diff    = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_last    = (r_cnt == c_LAST);
    assign w_accept  = bus.in_start && (r_state == S_IDLE || r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_start) w_next = S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = bus.in_start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_d_out <= '0;
            r_b_out <= 1'b0;
        end else if (w_accept) begin
            r_a   <= bus.in_a;
            r_b   <= bus.in_b;
            r_res <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_br_next;
            r_res <= {w_diff, r_res[WIDTH-1:1]};
            r_cnt <= r_cnt + 1'b1;
            // Final borrow doubles as the sign of the difference
            if (w_last) begin
                r_d_out <= {{WIDTH{w_br_next}}, w_diff, r_res[WIDTH-1:1]};
                r_b_out <= w_br_next;
            end
        end
    end

    assign bus.d_out = r_d_out;
    assign bus.b_out = r_b_out;
    assign bus.busy  = w_busy;
    assign bus.done  = w_done;

endmodule

`default_nettype wire

// File: tb/tb_three_bit_serial_subtractor.sv
// ============================================================================
// Module   : tb_three_bit_serial_subtractor
// Brief    : Self-checking bench against an arithmetic reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_three_bit_serial_subtractor;
    localparam int WIDTH = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [2*WIDTH-1:0] exp_d = '0;
    logic               exp_b = 1'b0;

    three_bit_serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    three_bit_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed difference truncated to 2*WIDTH bits, borrow = a < b
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int diff;
        diff  = int'(a) - int'(b);
        exp_d = (2*WIDTH)'(diff);
        exp_b = (a < b);
    endtask

    // Starts an operation from IDLE/DONE; returns positioned in the DONE cycle.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input bit scramble);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_start = 1'b1;
        tick();
        bus.in_start = 1'b0;
        if (scramble) begin
            bus.in_a = WIDTH'($urandom);
            bus.in_b = WIDTH'($urandom);
        end
        for (int c = 1; c <= WIDTH; c++) begin
            check("run_busy", 32'(bus.busy), 32'd1);
            check("run_done", 32'(bus.done), 32'd0);
            check("run_hold", 32'(bus.d_out), 32'(exp_d));
            tick();
        end
        model(a, b);
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd0);
        check("d_out", 32'(bus.d_out), 32'(exp_d));
        check("b_out", 32'(bus.b_out), 32'(exp_b));
    endtask

    task automatic settle_idle();
        tick();
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_hold", 32'(bus.d_out), 32'(exp_d));
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_start = 1'b0;
        rst          = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_d", 32'(bus.d_out), 32'd0);
        check("rst_b", 32'(bus.b_out), 32'd0);

        // Directed cases
        run_op(3'd5, 3'd3, 1'b0);
        check("d_5m3", 32'(bus.d_out), 32'h02);
        settle_idle();
        run_op(3'd3, 3'd5, 1'b0);
        check("d_3m5", 32'(bus.d_out), 32'h3E);
        settle_idle();
        run_op(3'd0, 3'd7, 1'b0);
        check("d_0m7", 32'(bus.d_out), 32'h39);
        settle_idle();
        run_op(3'd7, 3'd7, 1'b0);
        check("d_7m7", 32'(bus.d_out), 32'h00);
        settle_idle();
        run_op(3'd7, 3'd0, 1'b0);
        check("d_7m0", 32'(bus.d_out), 32'h07);
        settle_idle();
        run_op(3'd0, 3'd0, 1'b0);
        settle_idle();

        // Back-to-back with in_start held high
        bus.in_a = 3'd6; bus.in_b = 3'd1; bus.in_start = 1'b1;
        tick();
        bus.in_a = 3'd0; bus.in_b = 3'd7;
        for (int c = 1; c <= WIDTH; c++) begin
            check("b2b_busy1", 32'(bus.busy), 32'd1);
            if (c == WIDTH) begin
                bus.in_a = 3'd2; bus.in_b = 3'd4;
            end
            tick();
        end
        check("b2b_done1", 32'(bus.done), 32'd1);
        check("b2b_d1", 32'(bus.d_out), 32'h05);
        check("b2b_b1", 32'(bus.b_out), 32'd0);
        tick();
        bus.in_a = 3'd7; bus.in_b = 3'd0;
        for (int c = 1; c <= WIDTH; c++) begin
            check("b2b_busy2", 32'(bus.busy), 32'd1);
            check("b2b_hold", 32'(bus.d_out), 32'h05);
            if (c < WIDTH) tick();
        end
        bus.in_start = 1'b0;
        tick();
        check("b2b_done2", 32'(bus.done), 32'd1);
        check("b2b_d2", 32'(bus.d_out), 32'h3E);
        check("b2b_b2", 32'(bus.b_out), 32'd1);
        exp_d = 6'h3E;
        settle_idle();

        // Operand change plus extra start pulse in cycle 2 must be ignored
        bus.in_a = 3'd5; bus.in_b = 3'd3; bus.in_start = 1'b1;
        tick();
        bus.in_start = 1'b0;
        tick();
        bus.in_a = 3'd0; bus.in_b = 3'd7; bus.in_start = 1'b1;
        tick();
        bus.in_start = 1'b0;
        tick();
        check("ign_done", 32'(bus.done), 32'd1);
        check("ign_d", 32'(bus.d_out), 32'h02);
        exp_d = 6'h02;
        settle_idle();
        settle_idle();

        // Reset in cycle 2 of 3-5 aborts without a done pulse
        bus.in_a = 3'd3; bus.in_b = 3'd5; bus.in_start = 1'b1;
        tick();
        bus.in_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_d", 32'(bus.d_out), 32'd0);
        check("abort_b", 32'(bus.b_out), 32'd0);
        exp_d = '0;
        for (int c = 0; c < 4; c++) settle_idle();
        run_op(3'd4, 3'd1, 1'b0);
        check("d_4m1", 32'(bus.d_out), 32'h03);
        settle_idle();

        // Reset wins over a simultaneous start
        rst = 1'b1; bus.in_start = 1'b1;
        tick();
        rst = 1'b0; bus.in_start = 1'b0;
        exp_d = '0;
        check("rst_start_d", 32'(bus.d_out), 32'd0);
        settle_idle();

        // Randomized operations, occasionally back-to-back
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            run_op(ra, rb, 1'b1);
            if ($urandom_range(0, 1) == 0) settle_idle();
        end
        settle_idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
